// File: rtl/lcd_frame_read_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : lcd_sched_pkg
// Brief  : Shared types, constants and helpers for the LCD frame read
//          scheduler (state encoding, counter widths, burst length clamp).
// Rev    : 1.0 - initial release
// ============================================================================
package lcd_sched_pkg;

  // Scheduler states, explicitly encoded in 3 bits
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    BURST = 3'd4
  } sched_state_e;

  // Number of cycles the pixel FIFO clear is held
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned FLUSH_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  // Frame offset / remaining-word counters and burst length widths
  localparam int unsigned CNT_W = 20;
  localparam int unsigned LEN_W = 9;

  // Length of the next burst: a full burst, or whatever is left of the frame
  function automatic logic [LEN_W-1:0] min_len(input logic [CNT_W-1:0] words_left,
                                               input logic [CNT_W-1:0] burst_len);
    if (words_left < burst_len) begin
      return words_left[LEN_W-1:0];
    end
    return burst_len[LEN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : lcd_frame_read_scheduler_if
// Brief  : SDRAM read-port request/grant/completion bundle between the
//          frame read scheduler (master) and the read-port arbiter (slave).
// Rev    : 1.0 - initial release
// ============================================================================
interface lcd_frame_read_scheduler_if
  import lcd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
);
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_done;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface
`default_nettype wire

// File: rtl/lcd_frame_read_scheduler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : lcd_burst_addr_gen
// Brief  : Tracks the displayed bank, frame offset and remaining words, and
//          produces the start address and length of each read burst.
// Rev    : 1.0 - initial release
// ============================================================================
module lcd_burst_addr_gen
  import lcd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BANK_STRIDE = 524288,
  parameter int unsigned BURST_LEN   = 256
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,       // restart the frame
  input  wire logic              load_bank,  // bank to display for the new frame
  input  wire logic              issue,      // capture the next burst descriptor
  input  wire logic              advance,    // current burst has landed
  output logic                   bank,
  output logic [CNT_W-1:0]       words_left,
  output logic [ADDR_W-1:0]      addr,
  output logic [LEN_W-1:0]       len
);

  localparam logic [CNT_W-1:0]  c_frame_words = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0]  c_burst_len   = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] c_bank_stride = ADDR_W'(BANK_STRIDE);

  logic [CNT_W-1:0]  r_offset;
  logic [CNT_W-1:0]  r_words_left;
  logic              r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] w_base;

  assign w_base = r_bank ? c_bank_stride : '0;

  // Frame position: reset to the frame start on load, step by the burst just completed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset     <= '0;
      r_words_left <= '0;
      r_bank       <= 1'b0;
    end else if (load) begin
      r_offset     <= '0;
      r_words_left <= c_frame_words;
      r_bank       <= load_bank;
    end else if (advance) begin
      r_offset     <= r_offset + CNT_W'(r_len);
      r_words_left <= r_words_left - CNT_W'(r_len);
    end
  end

  // Burst descriptor: frozen from issue until the next issue so it stays stable while requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
    end else if (issue) begin
      r_len  <= min_len(r_words_left, c_burst_len);
      r_addr <= w_base + ADDR_W'(r_offset);
    end
  end

  assign bank       = r_bank;
  assign words_left = r_words_left;
  assign addr       = r_addr;
  assign len        = r_len;

endmodule
`default_nettype wire

// File: rtl/lcd_frame_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module : lcd_frame_read_scheduler
// Brief  : Keeps the LCD pixel FIFO ahead of the display by issuing SDRAM
//          read bursts; on each frame start it flushes the FIFO and switches
//          to the newest completed ping-pong bank.
// Rev    : 1.0 - initial release
// ============================================================================
module lcd_frame_read_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BANK_STRIDE = 524288,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned LVL_W       = 11
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   lcd_framesync,
  input  wire logic                   lcd_request,
  input  wire logic [LVL_W-1:0]       fifo_rdusedw,
  output logic                        fifo_aclr,
  input  wire logic                   wr_frame_done,
  input  wire logic                   wr_bank,
  lcd_frame_read_scheduler_if.master  rd,
  output logic                        rd_bank,
  output logic                        underflow
);

  // A burst is only requested when the whole burst is guaranteed to fit
  localparam logic [LVL_W-1:0]   c_fill_max   = LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [FLUSH_W-1:0] c_flush_last = FLUSH_W'(FLUSH_CYC - 1);

  sched_state_e       r_state;
  sched_state_e       w_next_state;
  logic               r_vs_d;
  logic               r_fs_edge;
  logic               r_latest_bank;
  logic               r_pending;
  logic               r_underflow;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic               w_load;
  logic               w_issue;
  logic               w_advance;
  logic               w_rd_req;
  logic               w_aclr;
  logic               w_bank_sel;
  logic [CNT_W-1:0]   w_words_left;

  // A bank completed in the same cycle as the frame start must win over the latched one
  assign w_bank_sel = wr_frame_done ? wr_bank : r_latest_bank;

  // Registered falling-edge detect on the active-low vsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d    <= 1'b1;
      r_fs_edge <= 1'b0;
    end else begin
      r_vs_d    <= lcd_framesync;
      r_fs_edge <= r_vs_d & ~lcd_framesync;
    end
  end

  // Remember the most recently completed bank from the writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latest_bank <= 1'b0;
    end else if (wr_frame_done) begin
      r_latest_bank <= wr_bank;
    end
  end

  // Frame start seen while a burst is outstanding: flush once that burst has landed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (r_state == FLUSH) begin
      r_pending <= 1'b0;
    end else if (r_fs_edge && (r_state == REQ || r_state == BURST)) begin
      r_pending <= 1'b1;
    end
  end

  // Flush length counter; a new frame start during the flush restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
    end else if (r_state != FLUSH || r_fs_edge) begin
      r_flush_cnt <= '0;
    end else begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Sticky underflow: the display popped an empty FIFO outside a deliberate flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (lcd_request && fifo_rdusedw == '0 && r_state != FLUSH) begin
      r_underflow <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    w_advance    = 1'b0;
    w_rd_req     = 1'b0;
    w_aclr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_fs_edge) w_next_state = FLUSH;
      end
      FLUSH: begin
        w_aclr = 1'b1;
        w_load = 1'b1;
        if (!r_fs_edge && r_flush_cnt == c_flush_last) w_next_state = CHECK;
      end
      CHECK: begin
        if (r_fs_edge) begin
          w_next_state = FLUSH;
        end else if (w_words_left == '0) begin
          w_next_state = IDLE;
        end else if (fifo_rdusedw <= c_fill_max) begin
          w_issue      = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_rd_req = 1'b1;
        if (rd.rd_ack) w_next_state = BURST;
      end
      BURST: begin
        if (rd.rd_done) begin
          w_advance    = 1'b1;
          w_next_state = (r_pending || r_fs_edge) ? FLUSH : CHECK;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  lcd_burst_addr_gen #(
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (FRAME_WORDS),
    .BANK_STRIDE (BANK_STRIDE),
    .BURST_LEN   (BURST_LEN)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .load_bank  (w_bank_sel),
    .issue      (w_issue),
    .advance    (w_advance),
    .bank       (rd_bank),
    .words_left (w_words_left),
    .addr       (rd.rd_addr),
    .len        (rd.rd_len)
  );

  assign rd.rd_req = w_rd_req;
  assign fifo_aclr = w_aclr;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_frame_read_scheduler
// Brief  : Self-checking bench for the LCD frame read scheduler. Instance A
//          uses the default 640x480 frame, instance B a 1000-word frame.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_read_scheduler;

  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned LVL_W    = 11;
  localparam int unsigned BURST    = 256;
  localparam int unsigned STRIDE   = 524288;
  localparam int unsigned FW_A     = 307200;
  localparam int unsigned FW_B     = 1000;
  localparam int unsigned FILL_MAX = 1024 - 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             framesync = 1'b1;
  logic             lcd_request = 1'b0;
  logic             wr_frame_done = 1'b0;
  logic             wr_bank = 1'b0;
  logic             ack = 1'b0;
  logic             done = 1'b0;
  logic             sel = 1'b0;
  logic [LVL_W-1:0] rdusedw = '0;

  logic fs_a, fs_b, wfd_a, wfd_b;
  logic aclr_a, aclr_b, bank_a, bank_b, uf_a, uf_b;
  logic obs_req, obs_aclr, obs_bank, obs_uf;
  logic [ADDR_W-1:0] obs_addr;
  logic [8:0]        obs_len;

  lcd_frame_read_scheduler_if #(.ADDR_W(ADDR_W)) rd_a ();
  lcd_frame_read_scheduler_if #(.ADDR_W(ADDR_W)) rd_b ();

  // Only the selected instance sees frame starts, writer pulses and arbiter responses
  assign fs_a         = sel ? 1'b1 : framesync;
  assign fs_b         = sel ? framesync : 1'b1;
  assign wfd_a        = wr_frame_done & ~sel;
  assign wfd_b        = wr_frame_done & sel;
  assign rd_a.rd_ack  = ack & ~sel;
  assign rd_a.rd_done = done & ~sel;
  assign rd_b.rd_ack  = ack & sel;
  assign rd_b.rd_done = done & sel;

  assign obs_req  = sel ? rd_b.rd_req  : rd_a.rd_req;
  assign obs_addr = sel ? rd_b.rd_addr : rd_a.rd_addr;
  assign obs_len  = sel ? rd_b.rd_len  : rd_a.rd_len;
  assign obs_aclr = sel ? aclr_b : aclr_a;
  assign obs_bank = sel ? bank_b : bank_a;
  assign obs_uf   = sel ? uf_b   : uf_a;

  lcd_frame_read_scheduler dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .lcd_framesync (fs_a),
    .lcd_request   (lcd_request),
    .fifo_rdusedw  (rdusedw),
    .fifo_aclr     (aclr_a),
    .wr_frame_done (wfd_a),
    .wr_bank       (wr_bank),
    .rd            (rd_a),
    .rd_bank       (bank_a),
    .underflow     (uf_a)
  );

  lcd_frame_read_scheduler #(.FRAME_WORDS(FW_B)) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .lcd_framesync (fs_b),
    .lcd_request   (lcd_request),
    .fifo_rdusedw  (rdusedw),
    .fifo_aclr     (aclr_b),
    .wr_frame_done (wfd_b),
    .wr_bank       (wr_bank),
    .rd            (rd_b),
    .rd_bank       (bank_b),
    .underflow     (uf_b)
  );

  // Reference model: a frame is the list of bursts covering it, clamped at the end
  typedef struct {
    int unsigned addr;
    int unsigned len;
  } burst_t;

  burst_t      exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned last_obs_addr;

  function automatic void build_frame(input int unsigned fw, input int unsigned bank);
    burst_t b;
    exp_q.delete();
    for (int unsigned off = 0; off < fw; off += BURST) begin
      b.addr = bank * STRIDE + off;
      b.len  = (fw - off < BURST) ? fw - off : BURST;
      exp_q.push_back(b);
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the first negedge where rd_req is seen
  task automatic wait_req(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (obs_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // Serve one expected burst with random grant/completion delays and FIFO levels
  task automatic serve(input burst_t b, input bit rand_lvl, output bit ok);
    bit hold;
    wait_req(64, ok);
    if (!ok) return;
    check("burst_addr", 32'(obs_addr), b.addr);
    check("burst_len", 32'(obs_len), b.len);
    last_obs_addr = 32'(obs_addr);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("req_drop_after_ack", 32'(obs_req), 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    hold = rand_lvl && ($urandom_range(0, 3) == 0);
    done = 1'b1;
    rdusedw = hold ? LVL_W'($urandom_range(FILL_MAX + 1, 1023))
                   : LVL_W'($urandom_range(0, FILL_MAX));
    @(negedge clk);
    done = 1'b0;
    if (hold) begin
      repeat (3) @(negedge clk);
      check("no_req_fifo_full", 32'(obs_req), 32'd0);
      rdusedw = LVL_W'($urandom_range(0, FILL_MAX));
    end
  endtask

  task automatic serve_frame(input int unsigned fw, input int unsigned bank, input bit rand_lvl);
    int unsigned n_exp;
    int unsigned n_got;
    bit ok;
    build_frame(fw, bank);
    n_exp = exp_q.size();
    n_got = 0;
    while (exp_q.size() > 0) begin
      serve(exp_q.pop_front(), rand_lvl, ok);
      if (!ok) break;
      n_got++;
    end
    check("burst_count", n_got, n_exp);
  endtask

  task automatic expect_quiet(input string tag, input int cyc);
    bit seen = 1'b0;
    repeat (cyc) begin
      @(negedge clk);
      if (obs_req) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  // Watchdog so a stuck DUT can never hang the run
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_req;
    int  first_aclr;
    int  n_aclr;
    bit  req_seen;
    bit  ok;
    bit  unused_ok;
    burst_t b;

    // ---- reset ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_aclr", 32'(obs_aclr), 32'd0);
    check("rst_req", 32'(obs_req), 32'd0);
    check("rst_addr", 32'(obs_addr), 32'd0);
    check("rst_len", 32'(obs_len), 32'd0);
    check("rst_bank", 32'(obs_bank), 32'd0);
    check("rst_underflow", 32'(obs_uf), 32'd0);

    // ---- frame start latency with an empty FIFO ----
    framesync = 1'b0;
    first_req = 0; first_aclr = 0; n_aclr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (obs_aclr) begin
        n_aclr++;
        if (first_aclr == 0) first_aclr = c;
      end
      if (obs_req && first_req == 0) first_req = c;
    end
    check("t1_aclr_cycles", n_aclr, 2);
    check("t1_aclr_start", first_aclr, 2);
    check("t1_req_latency", first_req, 5);
    check("t1_addr", 32'(obs_addr), 32'd0);
    check("t1_len", 32'(obs_len), BURST);
    framesync = 1'b1;

    // ---- full frame from bank 0 with random delays and FIFO levels ----
    serve_frame(FW_A, 0, 1'b1);
    check("t2_last_addr", last_obs_addr, 32'd306944);
    expect_quiet("t2_idle_no_req", 30);

    // ---- FIFO too full: flush happens, no request; pops during flush are not underflow ----
    check("t6_uf_before", 32'(obs_uf), 32'd0);
    rdusedw = LVL_W'(800);
    framesync = 1'b0;
    n_aclr = 0; req_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (obs_aclr) n_aclr++;
      if (obs_req) req_seen = 1'b1;
      if (c == 3) begin
        lcd_request = 1'b1;
        rdusedw = '0;
      end else if (c == 4) begin
        lcd_request = 1'b0;
        rdusedw = LVL_W'(800);
      end
    end
    framesync = 1'b1;
    check("t6_aclr_cycles", n_aclr, 2);
    check("t6_no_req_800", 32'(req_seen), 32'd0);
    check("t6_no_uf_in_flush", 32'(obs_uf), 32'd0);
    rdusedw = '0;
    @(negedge clk);
    wait_req(4, ok);
    check("t6_addr", 32'(obs_addr), 32'd0);
    check("t6_len", 32'(obs_len), BURST);
    lcd_request = 1'b1;
    @(negedge clk);
    lcd_request = 1'b0;
    check("t6_uf_set", 32'(obs_uf), 32'd1);
    repeat (5) @(negedge clk);
    check("t6_uf_sticky", 32'(obs_uf), 32'd1);

    // ---- writer finishes bank 1; frame start arrives mid-burst ----
    wr_bank = 1'b1;
    wr_frame_done = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    framesync = 1'b0;
    req_seen = 1'b0; n_aclr = 0;
    repeat (6) begin
      @(negedge clk);
      if (obs_req) req_seen = 1'b1;
      if (obs_aclr) n_aclr++;
    end
    framesync = 1'b1;
    check("t5_no_req_in_burst", 32'(req_seen), 32'd0);
    check("t5_no_flush_in_burst", n_aclr, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    first_req = 0; first_aclr = 0; n_aclr = 0;
    for (int c = 1; c <= 6; c++) begin
      if (obs_aclr) begin
        n_aclr++;
        if (first_aclr == 0) first_aclr = c;
      end
      if (obs_req && first_req == 0) first_req = c;
      if (c < 6) @(negedge clk);
    end
    check("t5_aclr_cycles", n_aclr, 2);
    check("t5_aclr_start", first_aclr, 1);
    check("t5_req_after_flush", first_req, 4);
    check("t4_bank", 32'(obs_bank), 32'd1);
    build_frame(FW_A, 1);
    for (int k = 0; k < 3; k++) begin
      b = exp_q.pop_front();
      serve(b, 1'b0, unused_ok);
    end
    check("t4_uf_still_set", 32'(obs_uf), 32'd1);

    // ---- short frame on instance B: 256,256,256,232 ----
    sel = 1'b1;
    rdusedw = '0;
    @(negedge clk);
    @(negedge clk);
    framesync = 1'b0;
    @(negedge clk);
    serve_frame(FW_B, 0, 1'b1);
    framesync = 1'b1;
    check("t3_last_len", 32'(obs_len), 32'd232);
    expect_quiet("t3_idle_no_req", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
